// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: reads 32-bit words over the shared bus, decodes the fields and
// hands each instruction to the execution engine through a valid/ready handshake.
module instruction_fetch_unit #(
  parameter logic [3:0]  INSTR_SELECT = 4'b1000,
  parameter int unsigned DEPTH        = 10
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [11:0]  StartPc,
  output logic [15:0]  address,
  output logic         nRead,
  input  logic [255:0] DataIn,
  output logic         InstrValid,
  input  logic         InstrReady,
  output logic [7:0]   Opcode,
  output logic [7:0]   Dest,
  output logic [7:0]   Src1,
  output logic [7:0]   Src2,
  output logic         IsMatrix,
  output logic         IsInteger,
  output logic [11:0]  Pc,
  output logic         Busy,
  output logic         Halted,
  output logic         Error
);

  localparam logic [11:0] LastPc = 12'(DEPTH - 1);

  typedef enum logic [2:0] {StIdle, StReq, StCapt, StIssue, StHalt} state_e;

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        is_matrix_q, is_matrix_d;
  logic        is_integer_q, is_integer_d;
  logic        error_q, error_d;

  logic [7:0]  data_op;
  logic        data_matrix, data_integer;
  logic        unused_data;

  assign data_op      = DataIn[31:24];
  assign data_matrix  = (data_op <= 8'h05);
  assign data_integer = (data_op >= 8'h10) && (data_op <= 8'h13);
  // Only the low word carries the instruction.
  assign unused_data  = ^DataIn[255:32];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      instr_q      <= '0;
      is_matrix_q  <= 1'b0;
      is_integer_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      is_matrix_q  <= is_matrix_d;
      is_integer_q <= is_integer_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    is_matrix_d  = is_matrix_q;
    is_integer_d = is_integer_q;
    error_d      = error_q;
    unique case (state_q)
      StIdle, StHalt: begin
        if (Start) begin
          pc_d    = StartPc;
          error_d = 1'b0;
          if (StartPc > LastPc) begin
            state_d = StHalt;
            error_d = 1'b1;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: state_d = StCapt;
      StCapt: begin
        instr_d      = DataIn[31:0];
        is_matrix_d  = data_matrix;
        is_integer_d = data_integer;
        if (data_op == 8'hFF) begin
          state_d = StHalt;
          error_d = 1'b0;
        end else if (data_matrix || data_integer) begin
          state_d = StIssue;
        end else begin
          state_d = StHalt;
          error_d = 1'b1;
        end
      end
      StIssue: begin
        if (InstrReady) begin
          // Running off the end of memory without a STOP is an error.
          if (pc_q == LastPc) begin
            state_d = StHalt;
            error_d = 1'b1;
          end else begin
            pc_d    = pc_q + 12'd1;
            state_d = StReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    nRead      = (state_q != StReq);
    address    = (state_q == StReq) ? {INSTR_SELECT, pc_q} : 16'h0000;
    InstrValid = (state_q == StIssue);
    Busy       = (state_q == StReq) || (state_q == StCapt) || (state_q == StIssue);
    Halted     = (state_q == StHalt);
    Error      = error_q;
    Opcode     = instr_q[31:24];
    Dest       = instr_q[23:16];
    Src1       = instr_q[15:8];
    Src2       = instr_q[7:0];
    IsMatrix   = is_matrix_q;
    IsInteger  = is_integer_q;
    Pc         = pc_q;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized programs
// compared against a program-level reference model.
module tb_instruction_fetch_unit;

  logic         Clk = 1'b0;
  logic         Reset, Start, InstrReady;
  logic [11:0]  StartPc;
  logic [15:0]  address;
  logic         nRead;
  logic [255:0] DataIn;
  logic         InstrValid, IsMatrix, IsInteger, Busy, Halted, Error;
  logic [7:0]   Opcode, Dest, Src1, Src2;
  logic [11:0]  Pc;

  int checks = 0;
  int failures = 0;
  int n_reads = 0;
  logic [31:0] mem [0:15];

  instruction_fetch_unit #(.INSTR_SELECT(4'b1000), .DEPTH(10)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartPc(StartPc), .address(address),
    .nRead(nRead), .DataIn(DataIn), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Opcode(Opcode), .Dest(Dest), .Src1(Src1), .Src2(Src2), .IsMatrix(IsMatrix),
    .IsInteger(IsInteger), .Pc(Pc), .Busy(Busy), .Halted(Halted), .Error(Error)
  );

  always #5 Clk = ~Clk;

  function automatic logic [223:0] junk();
    logic [223:0] r;
    for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Instruction memory: a read strobe seen at an edge presents the word during the next cycle.
  always @(posedge Clk) begin
    if (!nRead) begin
      DataIn  <= {junk(), mem[address[3:0]]};
      n_reads <= n_reads + 1;
    end else begin
      DataIn <= {junk(), 32'($urandom)};
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; Start = 1'b0; InstrReady = 1'b0; StartPc = '0;
    tick(); tick();
    Reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [11:0] sp);
    Start = 1'b1; StartPc = sp;
    tick();
    Start = 1'b0; StartPc = 12'($urandom);
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; InstrReady = 1'b1; StartPc = '0;
    tick(); tick();
    checks++;
    if ({nRead, address, InstrValid, Opcode, Dest, Src1, Src2, IsMatrix, IsInteger, Pc, Busy,
         Halted, Error} !== {1'b1, 16'h0, 1'b0, 32'h0, 2'b00, 12'h0, 3'b000}) begin
      failures++;
      $display("FAIL reset_values: got nRead=%b addr=%h v=%b fields=%h m=%b i=%b pc=%h bhe=%b%b%b",
               nRead, address, InstrValid, {Opcode, Dest, Src1, Src2}, IsMatrix, IsInteger, Pc,
               Busy, Halted, Error);
    end
    Reset = 1'b0; InstrReady = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    mem[0] = 32'h10020001; mem[1] = 32'hFF000000;
    InstrReady = 1'b1;
    pulse_start(12'd0);
    checks++;
    if ({nRead, address} !== {1'b0, 16'h8000}) begin
      failures++; $display("FAIL basic_req: got nRead=%b addr=%h want 0/8000", nRead, address);
    end
    tick();
    checks++;
    if ({nRead, InstrValid} !== 2'b10) begin
      failures++; $display("FAIL basic_capt: got nRead=%b valid=%b want 1/0", nRead, InstrValid);
    end
    tick();
    checks++;
    if ({InstrValid, Opcode, Dest, Src1, Src2, IsInteger, IsMatrix, Pc}
        !== {1'b1, 32'h10020001, 2'b10, 12'd0}) begin
      failures++;
      $display("FAIL basic_issue: got v=%b fields=%h i=%b m=%b pc=%0d want 1 10020001 1 0 0",
               InstrValid, {Opcode, Dest, Src1, Src2}, IsInteger, IsMatrix, Pc);
    end
    tick();
    checks++;
    if ({nRead, address, InstrValid} !== {1'b0, 16'h8001, 1'b0}) begin
      failures++; $display("FAIL basic_req2: got nRead=%b addr=%h v=%b want 0/8001/0",
                           nRead, address, InstrValid);
    end
    tick(); tick();
    checks++;
    if ({Halted, Error, Busy, InstrValid, Opcode} !== {4'b1000, 8'hFF}) begin
      failures++; $display("FAIL basic_stop: got h=%b e=%b b=%b v=%b op=%h want 1 0 0 0 ff",
                           Halted, Error, Busy, InstrValid, Opcode);
    end
    tick(); tick();
    checks++;
    if ({InstrValid, Halted} !== 2'b01) begin
      failures++; $display("FAIL basic_stays_halted: got v=%b h=%b want 0/1", InstrValid, Halted);
    end
    InstrReady = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    mem[2] = 32'h02030300; mem[3] = 32'hFF000000;
    pulse_start(12'd2);
    tick(); tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({InstrValid, Opcode, Dest, Src1, Src2, IsMatrix, IsInteger, nRead, Pc}
          !== {1'b1, 32'h02030300, 3'b101, 12'd2}) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got v=%b fields=%h m=%b i=%b nRead=%b pc=%0d", c,
                 InstrValid, {Opcode, Dest, Src1, Src2}, IsMatrix, IsInteger, nRead, Pc);
      end
      tick();
    end
    InstrReady = 1'b1;
    tick();
    InstrReady = 1'b0;
    checks++;
    if ({nRead, address, InstrValid} !== {1'b0, 16'h8003, 1'b0}) begin
      failures++; $display("FAIL stall_release: got nRead=%b addr=%h v=%b want 0/8003/0",
                           nRead, address, InstrValid);
    end
    tick(); tick();
    checks++;
    if ({Halted, Error} !== 2'b10) begin
      failures++; $display("FAIL stall_stop: got h=%b e=%b want 1/0", Halted, Error);
    end
  endtask

  task automatic test_illegal();
    logic seen;
    do_reset();
    mem[4] = 32'h07000000;
    InstrReady = 1'b1;
    pulse_start(12'd4);
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      seen |= InstrValid;
      tick();
    end
    checks++;
    if ({seen, Halted, Error} !== 3'b011) begin
      failures++; $display("FAIL illegal_opcode: got seen_valid=%b h=%b e=%b want 0 1 1",
                           seen, Halted, Error);
    end
    InstrReady = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    mem[9] = 32'h12000000;
    InstrReady = 1'b1;
    pulse_start(12'd9);
    tick(); tick();
    checks++;
    if ({InstrValid, Opcode, IsInteger} !== {1'b1, 8'h12, 1'b1}) begin
      failures++; $display("FAIL overrun_issue: got v=%b op=%h i=%b want 1 12 1",
                           InstrValid, Opcode, IsInteger);
    end
    tick();
    checks++;
    if ({Halted, Error, Pc, InstrValid, nRead} !== {2'b11, 12'd9, 2'b01}) begin
      failures++; $display("FAIL overrun_halt: got h=%b e=%b pc=%0d v=%b nRead=%b want 1 1 9 0 1",
                           Halted, Error, Pc, InstrValid, nRead);
    end
    InstrReady = 1'b0;
  endtask

  task automatic test_bad_startpc();
    int reads_before;
    do_reset();
    reads_before = n_reads;
    pulse_start(12'd10);
    tick();
    checks++;
    if ({Halted, Error, Busy, n_reads - reads_before} !== {3'b110, 32'd0}) begin
      failures++; $display("FAIL bad_startpc: got h=%b e=%b b=%b reads=%0d want 1 1 0 0",
                           Halted, Error, Busy, n_reads - reads_before);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem[0] = 32'h10020001; mem[1] = 32'hFF000000;
    pulse_start(12'd0);
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if ({nRead, address, InstrValid, Opcode, Dest, Src1, Src2, IsMatrix, IsInteger, Pc, Busy,
         Halted, Error} !== {1'b1, 16'h0, 1'b0, 32'h0, 2'b00, 12'h0, 3'b000}) begin
      failures++;
      $display("FAIL reset_mid: got nRead=%b addr=%h v=%b fields=%h pc=%h bhe=%b%b%b",
               nRead, address, InstrValid, {Opcode, Dest, Src1, Src2}, Pc, Busy, Halted, Error);
    end
    pulse_start(12'd0);
    tick(); tick();
    checks++;
    if ({InstrValid, Opcode, Src2} !== {1'b1, 8'h10, 8'h01}) begin
      failures++; $display("FAIL reset_mid_restart: got v=%b op=%h src2=%h want 1 10 01",
                           InstrValid, Opcode, Src2);
    end
  endtask

  task automatic test_start_ignored();
    do_reset();
    mem[0] = 32'h10020001; mem[1] = 32'hFF000000;
    pulse_start(12'd0);
    tick(); tick();
    pulse_start(12'd5);
    checks++;
    if ({InstrValid, Pc, nRead, Busy} !== {1'b1, 12'd0, 2'b11}) begin
      failures++; $display("FAIL start_ignored: got v=%b pc=%0d nRead=%b b=%b want 1 0 1 1",
                           InstrValid, Pc, nRead, Busy);
    end
    InstrReady = 1'b1;
    tick();
    InstrReady = 1'b0;
    checks++;
    if ({nRead, address} !== {1'b0, 16'h8001}) begin
      failures++; $display("FAIL start_ignored_next: got nRead=%b addr=%h want 0/8001",
                           nRead, address);
    end
  endtask

  task automatic test_restart_from_halt();
    do_reset();
    mem[4] = 32'h07000000; mem[0] = 32'h01020304;
    pulse_start(12'd4);
    tick(); tick();
    pulse_start(12'd0);
    checks++;
    if ({Halted, Error, nRead, address} !== {3'b000, 16'h8000}) begin
      failures++; $display("FAIL restart: got h=%b e=%b nRead=%b addr=%h want 0 0 0 8000",
                           Halted, Error, nRead, address);
    end
    tick(); tick();
    checks++;
    if ({InstrValid, Opcode, Dest, Src1, Src2, IsMatrix} !== {1'b1, 32'h01020304, 1'b1}) begin
      failures++; $display("FAIL restart_issue: got v=%b fields=%h m=%b want 1 01020304 1",
                           InstrValid, {Opcode, Dest, Src1, Src2}, IsMatrix);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      logic [11:0] sp, pc;
      logic [7:0]  op;
      logic [43:0] exp;
      logic        err;
      int          pcs[$];
      logic [43:0] iss[$];
      int          cyc;
      pcs.delete(); iss.delete();
      for (int a = 0; a < 10; a++) begin
        case ($urandom % 8)
          0, 1, 2: op = 8'($urandom_range(0, 5));
          3, 4, 5: op = 8'($urandom_range(16, 19));
          6:       op = 8'hFF;
          default: op = ($urandom % 2) ? 8'($urandom_range(6, 15)) : 8'($urandom_range(20, 254));
        endcase
        mem[a] = {op, 24'($urandom)};
      end
      sp = 12'($urandom_range(0, 11));
      // Reference: walk the program one word at a time.
      pc = sp; err = 1'b0;
      if (sp > 12'd9) begin
        err = 1'b1;
      end else begin
        forever begin
          pcs.push_back(int'(pc));
          op = mem[pc[3:0]][31:24];
          if (op == 8'hFF) begin
            err = 1'b0; break;
          end else if (op <= 8'h05 || (op >= 8'h10 && op <= 8'h13)) begin
            iss.push_back({pc, mem[pc[3:0]]});
            if (pc == 12'd9) begin err = 1'b1; break; end
            pc = pc + 12'd1;
          end else begin
            err = 1'b1; break;
          end
        end
      end
      do_reset();
      pulse_start(sp);
      cyc = 0;
      while (!Halted && cyc < 300) begin
        if (!nRead) begin
          checks++;
          if (pcs.size() == 0) begin
            failures++; $display("FAIL rand_read[%0d]: unexpected read addr=%h", it, address);
          end else if (address !== {4'h8, 12'(pcs[0])}) begin
            failures++; $display("FAIL rand_read[%0d]: got addr=%h want %h", it, address,
                                 {4'h8, 12'(pcs[0])});
            void'(pcs.pop_front());
          end else begin
            void'(pcs.pop_front());
          end
        end
        if (InstrValid) begin
          checks++;
          if (iss.size() == 0) begin
            failures++; $display("FAIL rand_issue[%0d]: unexpected valid pc=%0d", it, Pc);
          end else begin
            exp = iss[0];
            op  = exp[31:24];
            if ({Pc, Opcode, Dest, Src1, Src2, IsMatrix, IsInteger}
                !== {exp, op <= 8'h05, op >= 8'h10 && op <= 8'h13}) begin
              failures++;
              $display("FAIL rand_issue[%0d]: got pc=%0d fields=%h m=%b i=%b want pc=%0d %h",
                       it, Pc, {Opcode, Dest, Src1, Src2}, IsMatrix, IsInteger, exp[43:32],
                       exp[31:0]);
            end
          end
        end
        InstrReady = 1'($urandom % 2);
        if (InstrReady && InstrValid && iss.size() > 0) void'(iss.pop_front());
        tick();
        cyc++;
      end
      InstrReady = 1'b0;
      checks++;
      if ({Halted, Error, Pc, InstrValid, 32'(pcs.size() + iss.size())}
          !== {1'b1, err, pc, 1'b0, 32'd0}) begin
        failures++;
        $display("FAIL rand_end[%0d]: got h=%b e=%b pc=%0d v=%b left=%0d want 1 %b %0d 0 0",
                 it, Halted, Error, Pc, InstrValid, pcs.size() + iss.size(), err, pc);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 16; a++) mem[a] = 32'hFF000000;
    Reset = 1'b1; Start = 1'b0; InstrReady = 1'b0; StartPc = '0;
    test_reset();
    test_basic();
    test_stall();
    test_illegal();
    test_overrun();
    test_bad_startpc();
    test_reset_mid();
    test_start_ignored();
    test_restart_from_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
